// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU request arbiter: FSM encoding, ALU opcodes, widths.
// No logic; no latency; no backpressure.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DATA_W_DEF = 8;
  localparam int CMD_W_DEF  = 4;
  localparam int STAT_W     = 16;

  localparam logic [3:0] op_add  = 4'h0;
  localparam logic [3:0] op_inc  = 4'h1;
  localparam logic [3:0] op_sub  = 4'h2;
  localparam logic [3:0] op_dec  = 4'h3;
  localparam logic [3:0] op_mul  = 4'h4;
  localparam logic [3:0] op_div  = 4'h5;
  localparam logic [3:0] op_shl  = 4'h6;
  localparam logic [3:0] op_shr  = 4'h7;
  localparam logic [3:0] op_and  = 4'h8;
  localparam logic [3:0] op_or   = 4'h9;
  localparam logic [3:0] op_inv  = 4'hA;
  localparam logic [3:0] op_nand = 4'hB;
  localparam logic [3:0] op_nor  = 4'hC;
  localparam logic [3:0] op_xor  = 4'hD;
  localparam logic [3:0] op_xnor = 4'hE;
  localparam logic [3:0] op_buf  = 4'hF;

endpackage

// File: rtl/alu_req_arbiter_if.sv
// Requester-side and ALU-side signals of the arbiter; slave = arbiter, master = clients + ALU.
// No latency; valid/ready handshakes on request and response.
interface alu_req_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 8,
  parameter int CMD_W   = 4
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ*CMD_W-1:0]  req_cmd;
  logic [NUM_REQ-1:0]        resp_valid;
  logic [NUM_REQ-1:0]        resp_ready;
  logic [2*DATA_W-1:0]       resp_data;
  logic [DATA_W-1:0]         alu_a;
  logic [DATA_W-1:0]         alu_b;
  logic [CMD_W-1:0]          alu_cmd;
  logic                      alu_en;
  logic [2*DATA_W-1:0]       alu_dout;

  modport slave (
    input  req_valid, req_a, req_b, req_cmd, resp_ready, alu_dout,
    output req_ready, resp_valid, resp_data, alu_a, alu_b, alu_cmd, alu_en
  );

  modport master (
    output req_valid, req_a, req_b, req_cmd, resp_ready, alu_dout,
    input  req_ready, resp_valid, resp_data, alu_a, alu_b, alu_cmd, alu_en
  );
endinterface

// File: rtl/alu_req_arbiter_rr_pick.sv
// Round-robin picker: first set req bit at or above ptr, with wrap; one-hot grant plus index.
// Combinational, zero latency; no backpressure of its own.
module rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);
  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        gnt[j] = 1'b1;
        idx    = IDX_W'(j);
        any    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/alu_req_arbiter.sv
// Round-robin share of one combinational ALU among NUM_REQ clients; optional ARB_STATS_EN busy counter.
// Result valid 2 clocks after the accept cycle; response held until the granted client's resp_ready.
module alu_req_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CMD_W   = CMD_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  alu_req_arbiter_if.slave   bus
`ifdef ARB_STATS_EN
  ,
  input  logic               stat_clr,
  output logic [STAT_W-1:0]  stat_busy
`endif
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t              state;
  logic [IDX_W-1:0]    rr_ptr;
  logic [IDX_W-1:0]    pick_idx;
  logic [IDX_W-1:0]    ptr_nxt;
  logic [NUM_REQ-1:0]  pick_gnt;
  logic                pick_any;
  logic [NUM_REQ-1:0]  gnt_q;
  logic [NUM_REQ-1:0]  resp_valid_q;
  logic [DATA_W-1:0]   alu_a_q;
  logic [DATA_W-1:0]   alu_b_q;
  logic [CMD_W-1:0]    alu_cmd_q;
  logic                alu_en_q;
  logic [2*DATA_W-1:0] resp_data_q;

  rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req (bus.req_valid),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign ptr_nxt = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);

  // Accept pulse is only meaningful while idle; the picker runs every cycle.
  assign bus.req_ready  = (state == IDLE) ? pick_gnt : '0;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_cmd    = alu_cmd_q;
  assign bus.alu_en     = alu_en_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      gnt_q        <= '0;
      resp_valid_q <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_cmd_q    <= '0;
      alu_en_q     <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            gnt_q     <= pick_gnt;
            alu_a_q   <= bus.req_a[pick_idx*DATA_W +: DATA_W];
            alu_b_q   <= bus.req_b[pick_idx*DATA_W +: DATA_W];
            alu_cmd_q <= bus.req_cmd[pick_idx*CMD_W +: CMD_W];
            rr_ptr    <= ptr_nxt;
            alu_en_q  <= 1'b1;
            state     <= EXEC;
          end
        end
        EXEC: begin
          resp_data_q  <= bus.alu_dout;
          alu_en_q     <= 1'b0;
          resp_valid_q <= gnt_q;
          state        <= RESP;
        end
        RESP: begin
          // Only the granted client's ready can retire the response.
          if (|(resp_valid_q & bus.resp_ready)) begin
            resp_valid_q <= '0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_STATS_EN
  logic [STAT_W-1:0] busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else if (stat_clr) begin
      busy_q <= '0;
    end else if ((state != IDLE) && (busy_q != '1)) begin
      busy_q <= busy_q + STAT_W'(1);
    end
  end

  assign stat_busy = busy_q;
`endif

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter with a behavioural 8-bit ALU on the ALU side.
// Stats checks are compiled in only when ARB_STATS_EN is defined.
module tb_alu_req_arbiter;
  import alu_arb_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  alu_req_arbiter_if #(.NUM_REQ(2), .DATA_W(8), .CMD_W(4)) bus ();

`ifdef ARB_STATS_EN
  logic        stat_clr;
  logic [15:0] stat_busy;
`endif

  alu_req_arbiter #(.NUM_REQ(2), .DATA_W(8), .CMD_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ARB_STATS_EN
    ,
    .stat_clr  (stat_clr),
    .stat_busy (stat_busy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU driven by the arbiter.
  always_comb begin
    bus.alu_dout = 16'h0;
    if (bus.alu_en) begin
      case (bus.alu_cmd)
        op_add:  bus.alu_dout = {8'h0, bus.alu_a} + {8'h0, bus.alu_b};
        op_inc:  bus.alu_dout = {8'h0, bus.alu_a} + 16'h1;
        op_sub:  bus.alu_dout = {8'h0, bus.alu_a} - {8'h0, bus.alu_b};
        op_dec:  bus.alu_dout = {8'h0, bus.alu_a} - 16'h1;
        op_mul:  bus.alu_dout = {8'h0, bus.alu_a} * {8'h0, bus.alu_b};
        op_div:  bus.alu_dout = (bus.alu_b == 8'h0) ? 16'hFFFF : {8'h0, bus.alu_a / bus.alu_b};
        op_shl:  bus.alu_dout = {8'h0, bus.alu_a} << 1;
        op_shr:  bus.alu_dout = {8'h0, bus.alu_a} >> 1;
        op_and:  bus.alu_dout = {8'h0, bus.alu_a & bus.alu_b};
        op_or:   bus.alu_dout = {8'h0, bus.alu_a | bus.alu_b};
        op_inv:  bus.alu_dout = {8'h0, ~bus.alu_a};
        op_nand: bus.alu_dout = {8'h0, ~(bus.alu_a & bus.alu_b)};
        op_nor:  bus.alu_dout = {8'h0, ~(bus.alu_a | bus.alu_b)};
        op_xor:  bus.alu_dout = {8'h0, bus.alu_a ^ bus.alu_b};
        op_xnor: bus.alu_dout = {8'h0, ~(bus.alu_a ^ bus.alu_b)};
        default: bus.alu_dout = {8'h0, bus.alu_a};
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst            = 1'b1;
    bus.req_valid  = 2'b00;
    bus.req_a      = 16'h0;
    bus.req_b      = 16'h0;
    bus.req_cmd    = 8'h0;
    bus.resp_ready = 2'b00;
`ifdef ARB_STATS_EN
    stat_clr       = 1'b0;
`endif
    step();
    step();
    chk("rst_req_ready",  32'(bus.req_ready),  32'h0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
    chk("rst_alu_en",     32'(bus.alu_en),     32'h0);
    chk("rst_alu_a",      32'(bus.alu_a),      32'h0);
    chk("rst_alu_b",      32'(bus.alu_b),      32'h0);
    chk("rst_alu_cmd",    32'(bus.alu_cmd),    32'h0);
    chk("rst_resp_data",  32'(bus.resp_data),  32'h0);
    rst = 1'b0;
    step();

    // 1) requester 0 Add 10+10
    bus.req_a      = {8'h00, 8'd10};
    bus.req_b      = {8'h00, 8'd10};
    bus.req_cmd    = {4'h0, op_add};
    bus.req_valid  = 2'b01;
    bus.resp_ready = 2'b11;
    #1;
    chk("t1_req_ready", 32'(bus.req_ready), 32'h1);
    step();
    chk("t1_exec_en",    32'(bus.alu_en),    32'h1);
    chk("t1_exec_a",     32'(bus.alu_a),     32'd10);
    chk("t1_exec_cmd",   32'(bus.alu_cmd),   32'h0);
    chk("t1_exec_ready", 32'(bus.req_ready), 32'h0);
    bus.req_valid = 2'b00;
    step();
    chk("t1_resp_valid", 32'(bus.resp_valid), 32'h1);
    chk("t1_resp_data",  32'(bus.resp_data),  32'd20);
    chk("t1_resp_en",    32'(bus.alu_en),     32'h0);
    step();
    chk("t1_idle_valid", 32'(bus.resp_valid), 32'h0);
    chk("t1_hold_a",     32'(bus.alu_a),      32'd10);

    // 2) both requesting continuously from reset: grants 0,1,0,1
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.req_a     = {8'h0F, 8'd1};
    bus.req_b     = {8'hFF, 8'd2};
    bus.req_cmd   = {op_xor, op_add};
    bus.req_valid = 2'b11;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("t2_grant", 32'(bus.req_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
      step();
      step();
      chk("t2_resp_valid", 32'(bus.resp_valid), (i % 2 == 0) ? 32'h1 : 32'h2);
      chk("t2_resp_data",  32'(bus.resp_data),  (i % 2 == 0) ? 32'h3 : 32'hF0);
      step();
    end

    // 3) requester 1 Mul FF*FF with a stalled response
    bus.req_a      = {8'hFF, 8'd20};
    bus.req_b      = {8'hFF, 8'd10};
    bus.req_cmd    = {op_mul, op_sub};
    bus.req_valid  = 2'b10;
    bus.resp_ready = 2'b00;
    #1;
    chk("t3_grant", 32'(bus.req_ready), 32'h2);
    step();
    bus.req_valid = 2'b01;
    step();
    chk("t3_resp_data", 32'(bus.resp_data), 32'hFE01);
    bus.resp_ready = 2'b01;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_hold_valid", 32'(bus.resp_valid), 32'h2);
      chk("t3_hold_data",  32'(bus.resp_data),  32'hFE01);
      chk("t3_no_grant",   32'(bus.req_ready),  32'h0);
    end
    bus.resp_ready = 2'b10;
    step();
    chk("t3_released", 32'(bus.resp_valid), 32'h0);

    // 4) requester 0 Sub 20-10, operands changed after accept
    chk("t4_grant", 32'(bus.req_ready), 32'h1);
    step();
    bus.req_valid  = 2'b00;
    bus.req_a      = {8'hFF, 8'd99};
    bus.req_b      = {8'hFF, 8'd1};
    bus.req_cmd    = {op_mul, op_add};
    bus.resp_ready = 2'b01;
    #1;
    chk("t4_latched_a", 32'(bus.alu_a), 32'd20);
    step();
    chk("t4_resp_valid", 32'(bus.resp_valid), 32'h1);
    chk("t4_resp_data",  32'(bus.resp_data),  32'd10);
    step();

    // 5) reset during EXEC
    bus.req_a      = {8'h00, 8'd5};
    bus.req_b      = {8'h00, 8'd5};
    bus.req_cmd    = {4'h0, op_add};
    bus.req_valid  = 2'b01;
    bus.resp_ready = 2'b11;
    #1;
    chk("t5_grant", 32'(bus.req_ready), 32'h1);
    step();
    chk("t5_exec_en", 32'(bus.alu_en), 32'h1);
    bus.req_valid = 2'b00;
    rst = 1'b1;
    #1;
    chk("t5_rst_en",        32'(bus.alu_en),     32'h0);
    chk("t5_rst_a",         32'(bus.alu_a),      32'h0);
    chk("t5_rst_b",         32'(bus.alu_b),      32'h0);
    chk("t5_rst_cmd",       32'(bus.alu_cmd),    32'h0);
    chk("t5_rst_resp_data", 32'(bus.resp_data),  32'h0);
    chk("t5_rst_valid",     32'(bus.resp_valid), 32'h0);
    step();
    rst = 1'b0;
    step();
    step();
    chk("t5_no_resp", 32'(bus.resp_valid), 32'h0);
    bus.req_a     = {8'h01, 8'h81};
    bus.req_cmd   = {op_inc, op_shl};
    bus.req_valid = 2'b11;
    #1;
    chk("t5_ptr_reset", 32'(bus.req_ready), 32'h1);
    step();
    bus.req_valid = 2'b00;
    step();
    chk("t5_shl_data", 32'(bus.resp_data), 32'h0102);
    step();

`ifdef ARB_STATS_EN
    // 6) busy-cycle counter
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_rst_busy", 32'(stat_busy), 32'h0);
    bus.req_a   = {8'h00, 8'd3};
    bus.req_b   = {8'h00, 8'd4};
    bus.req_cmd = {4'h0, op_add};
    for (int i = 0; i < 3; i++) begin
      bus.req_valid  = 2'b01;
      bus.resp_ready = 2'b00;
      step();
      bus.req_valid = 2'b00;
      step();
      step();
      bus.resp_ready = 2'b01;
      step();
    end
    bus.resp_ready = 2'b00;
    chk("t6_busy_9", 32'(stat_busy), 32'd9);
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    chk("t6_clr", 32'(stat_busy), 32'h0);
    bus.req_valid = 2'b01;
    step();
    bus.req_valid = 2'b00;
    stat_clr      = 1'b1;
    step();
    stat_clr = 1'b0;
    chk("t6_clr_wins", 32'(stat_busy), 32'h0);
    bus.resp_ready = 2'b01;
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
